kmac_absorb_ctrl: RTL and testbench
===================================

Name: kmac_absorb_ctrl

Overview:
- Sequences the sponge absorb phase of the KMAC/Keccak datapath.
- Packs an incoming byte stream into rate-sized blocks and applies pad10*1 with a domain-separation byte at message end.
- Hands each completed block to the Keccak permutation over a valid/ready handshake.
- Sits between the message source and the permutation core; one message in flight at a time.

Parameters:
- RATE_BYTES, 136, sponge rate in bytes (136 = KMAC256/SHA3-256, 168 = KMAC128); must be >= 2.
- DS_BYTE, 8'h04, domain-separation suffix byte (8'h04 KMAC/cSHAKE, 8'h06 SHA3); bit 7 must be 0.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  source offers a beat
- in_ready  out  1  controller accepts the beat this cycle
- in_data  in  8  message byte
- in_keep  in  1  1 = in_data is a message byte; 0 = no byte (end marker only, for empty messages)
- in_last  in  1  beat ends the message
- blk_valid  out  1  block on blk_data is ready for the permutation
- blk_ready  in  1  permutation accepts the block
- blk_data  out  RATE_BYTES*8  block; byte i at bits [8i+7:8i]
- blk_final  out  1  block carries the padding (last block of message)
- busy  out  1  high from first accepted beat until final block handshake
- done  out  1  one-cycle pulse the cycle after the final block handshake

Behaviour:
- Reset (async, any state): state=FILL, buffer all-zero, cnt=0, pad_pending=0, final=0. Outputs: in_ready=1, blk_valid=0, blk_final=0, busy=0, done=0, blk_data=0. An in-flight block is discarded.
- Handshakes: a beat transfers when in_valid&in_ready; a block transfers when blk_valid&blk_ready. blk_data and blk_final stay stable while blk_valid=1 and blk_ready=0.
- State FILL (in_ready=1):
  - keep=1 accept: byte written at index cnt, cnt+1.
  - If that byte fills index RATE_BYTES-1: go EMIT with final=0, pad_pending=in_last.
  - Else if in_last: go PAD.
  - keep=0, last=1: go PAD with no write.
  - keep=0, last=0: no-op.
- State PAD (one cycle, in_ready=0):
  - byte[cnt]=DS_BYTE; byte[RATE_BYTES-1] |= 8'h80.
  - When cnt==RATE_BYTES-1 the single byte becomes DS_BYTE|8'h80 (8'h84 default).
  - Set final=1, clear pad_pending, go EMIT.
- State EMIT (in_ready=0, blk_valid=1, blk_final=final):
  - On handshake: buffer cleared, cnt=0.
  - If final: go FILL and pulse done next cycle.
  - Else if pad_pending: go PAD (yields a pad-only block).
  - Else: go FILL.
- busy: set on first accepted beat in FILL; cleared with the final handshake.
- Latency: last beat accepted at cycle t with block not full -> PAD at t+1, blk_valid at t+2. A full block -> blk_valid at t+1.
- Widths: cnt is clog2(RATE_BYTES) bits and never exceeds RATE_BYTES-1.
- Illegal DS_BYTE bit 7 or RATE_BYTES<2 is rejected by an elaboration-time check.

Test Plan:
- Empty message (keep=0, last=1), RATE_BYTES=136 -> one block: byte0=8'h04, byte135=8'h80, all other bytes 0, blk_final=1; done pulses 1 cycle after handshake.
- Bytes AA, BB, CC (last on CC) -> byte0..2=AA,BB,CC, byte3=04, byte135=80, blk_final=1; blk_valid asserts 2 cycles after CC is accepted.
- 135-byte message 00..86 -> single block with byte135=8'h84, blk_final=1.
- 136-byte message -> block1 is all data with blk_final=0; block2 has byte0=04, byte135=80, blk_final=1; busy stays high across both blocks.
- Hold blk_ready=0 for 10 cycles in EMIT -> blk_data/blk_final stable, in_ready=0, next message bytes unaccepted; no loss after release.
- Assert rst during EMIT mid-message -> blk_valid=0 and busy=0 immediately; a following 1-byte message 5A yields byte0=5A, byte1=04, byte135=80.

Source files
------------

// File: rtl/kmac_absorb_ctrl.sv
// rtl/kmac_absorb_ctrl.sv - Keccak sponge absorb sequencer: byte packing, pad10*1, block handoff
// One message in flight; blocks are held stable on blk_data until the permutation takes them.
module kmac_absorb_ctrl #(
  parameter int unsigned RATE_BYTES = 136,
  parameter logic [7:0]  DS_BYTE    = 8'h04
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [RATE_BYTES*8-1:0] blk_data,
  output logic                    blk_final,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned   CW       = $clog2(RATE_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_BYTES - 1);

  if (RATE_BYTES < 2 || DS_BYTE[7]) begin : g_param_check
    $error("kmac_absorb_ctrl: RATE_BYTES must be >= 2 and DS_BYTE bit 7 must be 0");
  end

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [RATE_BYTES*8-1:0] buf_q;
  logic [RATE_BYTES*8-1:0] buf_fill_d;
  logic [RATE_BYTES*8-1:0] buf_pad_d;
  logic                    pad_pending_q;
  logic                    final_q;
  logic                    in_ready_q;
  logic                    blk_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    beat_acc;
  logic                    blk_hs;
  logic                    cnt_full;

  assign beat_acc = in_valid & in_ready_q;
  assign blk_hs   = blk_valid_q & blk_ready;
  assign cnt_full = (cnt_q == LAST_IDX);

  // Padding writes DS at cnt first, so a DS landing on the last byte merges with 8'h80.
  always_comb begin
    buf_fill_d = buf_q;
    buf_pad_d  = buf_q;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (cnt_q == CW'(i)) begin
        buf_fill_d[8*i +: 8] = in_data;
        buf_pad_d[8*i +: 8]  = DS_BYTE;
      end
    end
    buf_pad_d[8*(RATE_BYTES-1) +: 8] = buf_pad_d[8*(RATE_BYTES-1) +: 8] | 8'h80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      buf_q         <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      in_ready_q    <= 1'b1;
      blk_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_FILL: begin
          if (beat_acc && (in_keep || in_last)) busy_q <= 1'b1;
          if (beat_acc && in_keep) begin
            buf_q <= buf_fill_d;
            if (cnt_full) begin
              cnt_q         <= '0;
              final_q       <= 1'b0;
              pad_pending_q <= in_last;
              state_q       <= S_EMIT;
              in_ready_q    <= 1'b0;
              blk_valid_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (in_last) begin
                state_q    <= S_PAD;
                in_ready_q <= 1'b0;
              end
            end
          end else if (beat_acc && in_last) begin
            state_q    <= S_PAD;
            in_ready_q <= 1'b0;
          end
        end
        S_PAD: begin
          buf_q         <= buf_pad_d;
          final_q       <= 1'b1;
          pad_pending_q <= 1'b0;
          state_q       <= S_EMIT;
          blk_valid_q   <= 1'b1;
        end
        S_EMIT: begin
          if (blk_hs) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            blk_valid_q <= 1'b0;
            if (final_q) begin
              state_q    <= S_FILL;
              in_ready_q <= 1'b1;
              final_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (pad_pending_q) begin
              state_q <= S_PAD;
            end else begin
              state_q    <= S_FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = buf_q;
  assign blk_final = final_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_kmac_absorb_ctrl.sv
// tb/tb_kmac_absorb_ctrl.sv - randomized bench for kmac_absorb_ctrl against a pad10*1 message model
module tb_kmac_absorb_ctrl;
  localparam int         R  = 136;
  localparam logic [7:0] DS = 8'h04;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_keep, in_last;
  logic [7:0]     in_data;
  logic           blk_valid, blk_ready, blk_final, busy, done;
  logic [R*8-1:0] blk_data;

  int             n_cmp = 0;
  int             n_fail = 0;
  logic [7:0]     msg_q[$];
  int             lat;

  kmac_absorb_ctrl #(.RATE_BYTES(R), .DS_BYTE(DS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_final(blk_final), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [R*8-1:0] obs, input logic [R*8-1:0] exp);
    int d;
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      d = 0;
      for (int i = R - 1; i >= 0; i--) if (obs[8*i +: 8] !== exp[8*i +: 8]) d = i;
      $error("FAIL %s: byte %0d observed %0h expected %0h", tag, d, obs[8*d +: 8], exp[8*d +: 8]);
    end
  endtask

  // Sends msg_q (empty -> single keep=0/last=1 beat) and checks every block against the padded message.
  task automatic run_msg(input string tag, input int pv, input int pr, input int hold, output int lat_o);
    logic [7:0]     pad[$];
    logic [R*8-1:0] exp, held;
    logic           held_fin;
    int             nbeats, bi, nblk, bk, held_left, last_acc;
    bit             done_expect, finished;
    pad = msg_q;
    pad.push_back(DS);
    while (pad.size() % R != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    nblk = pad.size() / R;
    nbeats = (msg_q.size() == 0) ? 1 : msg_q.size();
    bi = 0; bk = 0; held_left = hold; last_acc = -1; lat_o = -1;
    done_expect = 0; finished = 0; held = '0; held_fin = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done_expect) begin
        chk({tag, ":done"}, done, 1'b1);
        chk({tag, ":busy_after"}, busy, 1'b0);
        finished = 1;
        break;
      end
      if (blk_valid && lat_o < 0 && last_acc >= 0) lat_o = cyc - last_acc;
      in_valid = (bi < nbeats) && ($urandom_range(99) < pv);
      in_keep  = (msg_q.size() != 0);
      in_data  = (in_keep && bi < nbeats) ? msg_q[bi] : 8'($urandom);
      in_last  = (bi == nbeats - 1);
      if (blk_valid && held_left > 0) begin
        if (held_left == hold) begin
          held = blk_data;
          held_fin = blk_final;
        end else begin
          chk_blk({tag, ":hold_data"}, blk_data, held);
          chk({tag, ":hold_final"}, blk_final, held_fin);
          chk({tag, ":hold_in_ready"}, in_ready, 1'b0);
        end
        held_left--;
        blk_ready = 1'b0;
        in_valid  = (bi < nbeats);
      end else begin
        blk_ready = ($urandom_range(99) < pr);
      end
      if (in_valid && in_ready) begin
        bi++;
        if (bi == nbeats) last_acc = cyc;
      end
      if (blk_valid && blk_ready) begin
        chk({tag, ":blk_in_range"}, bk < nblk, 1'b1);
        if (bk < nblk) begin
          for (int i = 0; i < R; i++) exp[8*i +: 8] = pad[bk*R + i];
          chk_blk({tag, ":blk_data"}, blk_data, exp);
          chk({tag, ":blk_final"}, blk_final, bk == nblk - 1);
          chk({tag, ":busy"}, busy, 1'b1);
          chk({tag, ":no_early_done"}, done, 1'b0);
        end
        bk++;
        if (bk == nblk) done_expect = 1;
      end
    end
    chk({tag, ":completed"}, finished, 1'b1);
    in_valid = 1'b0;
    blk_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:in_ready", in_ready, 1'b1);
    chk("rst:blk_valid", blk_valid, 1'b0);
    chk("rst:blk_final", blk_final, 1'b0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk_blk("rst:blk_data", blk_data, '0);
    rst = 1'b0;

    msg_q.delete();
    run_msg("empty", 100, 100, 0, lat);

    msg_q = '{8'hAA, 8'hBB, 8'hCC};
    run_msg("abc", 100, 100, 0, lat);
    chk("abc:latency", lat, 2);

    msg_q.delete();
    for (int i = 0; i < 135; i++) msg_q.push_back(8'(i));
    run_msg("len135", 100, 100, 0, lat);

    msg_q.delete();
    for (int i = 0; i < 136; i++) msg_q.push_back(8'($urandom));
    run_msg("len136", 100, 100, 0, lat);
    chk("len136:latency", lat, 1);

    msg_q.delete();
    for (int i = 0; i < 140; i++) msg_q.push_back(8'($urandom));
    run_msg("hold", 100, 100, 10, lat);

    // Reset while a full mid-message block waits in EMIT.
    @(negedge clk);
    in_keep = 1'b1; in_last = 1'b0;
    for (int i = 0; i < R; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 7);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rstmid:blk_valid_pre", blk_valid, 1'b1);
    chk("rstmid:busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid:blk_valid", blk_valid, 1'b0);
    chk("rstmid:busy", busy, 1'b0);
    chk("rstmid:in_ready", in_ready, 1'b1);
    chk_blk("rstmid:blk_data", blk_data, '0);
    @(negedge clk);
    rst = 1'b0;
    msg_q = '{8'h5A};
    run_msg("after_rst", 100, 100, 0, lat);

    for (int t = 0; t < 8; t++) begin
      msg_q.delete();
      for (int i = 0, n = $urandom_range(300); i < n; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", t), $urandom_range(30, 100), $urandom_range(30, 100),
              $urandom_range(0, 4), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
